// File: rtl/prbs7_checker_if.sv
// Bundle of the PRBS7 checker's stream, control and status signals.
// PRBS7_CHECKER_BITCNT_EN adds bit_cnt_o for BER measurement.
interface prbs7_checker_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 en_i;
    logic                 prbs_i;
    logic                 clear_i;
    logic                 locked_o;
    logic                 err_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;
`ifdef PRBS7_CHECKER_BITCNT_EN
    logic [ERR_CNT_W-1:0] bit_cnt_o;

    modport master (output en_i, prbs_i, clear_i,
                    input  locked_o, err_o, err_cnt_o, bit_cnt_o);
    modport slave  (input  en_i, prbs_i, clear_i,
                    output locked_o, err_o, err_cnt_o, bit_cnt_o);
`else
    modport master (output en_i, prbs_i, clear_i,
                    input  locked_o, err_o, err_cnt_o);
    modport slave  (input  en_i, prbs_i, clear_i,
                    output locked_o, err_o, err_cnt_o);
`endif
endinterface

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) receive checker with lock, error pulse and error count.
// Optional PRBS7_CHECKER_BITCNT_EN adds a saturating checked-bit counter (bit_cnt_o).
module prbs7_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 8,
    parameter int WIN_LEN     = 128,
    parameter int ERR_CNT_W   = 16
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    prbs7_checker_if.slave bus
);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WIN_LEN);
    localparam int WERR_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [MATCH_W-1:0] LOCK_LAST = MATCH_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0]  LOSS_LAST = WERR_W'(LOSS_THRESH - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t               state_q, state_d;
    logic [6:0]           hist_q, hist_d;
    logic [2:0]           fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [WERR_W-1:0]    werr_q, werr_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
`ifdef PRBS7_CHECKER_BITCNT_EN
    logic [ERR_CNT_W-1:0] bits_q, bits_d;
`endif

    logic pred;
    logic bit_err;

    assign pred    = hist_q[6] ^ hist_q[5];
    assign bit_err = bus.prbs_i ^ pred;

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        win_d   = win_q;
        werr_d  = werr_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
`ifdef PRBS7_CHECKER_BITCNT_EN
        bits_d  = bits_q;
`endif
        if (bus.en_i) begin
            case (state_q)
                SEARCH: begin
                    hist_d = {hist_q[5:0], bus.prbs_i};
                    if (fill_q != 3'd7) fill_d = fill_q + 3'd1;
                    // The all-zero history is the LFSR lockup state and must never count as a match.
                    if (fill_q == 3'd7 && hist_q != '0 && !bit_err) begin
                        if (match_q == LOCK_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    hist_d = {hist_q[5:0], pred};
                    err_d  = bit_err;
                    if (bit_err && cnt_q != '1) cnt_d = cnt_q + 1'b1;
`ifdef PRBS7_CHECKER_BITCNT_EN
                    if (bits_q != '1) bits_d = bits_q + 1'b1;
`endif
                    // The threshold test comes before the end-of-window clear.
                    if (bit_err && werr_q == LOSS_LAST) begin
                        state_d = SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_LAST) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                        if (bit_err) werr_d = werr_q + 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
        if (bus.clear_i) begin
            cnt_d = '0;
`ifdef PRBS7_CHECKER_BITCNT_EN
            bits_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SEARCH;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef PRBS7_CHECKER_BITCNT_EN
            bits_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef PRBS7_CHECKER_BITCNT_EN
            bits_q  <= bits_d;
`endif
        end
    end

    assign bus.locked_o  = (state_q == LOCKED);
    assign bus.err_o     = err_q;
    assign bus.err_cnt_o = cnt_q;
`ifdef PRBS7_CHECKER_BITCNT_EN
    assign bus.bit_cnt_o = bits_q;
`endif
endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: two instances (16-bit and 4-bit counters) fed the same stream,
// compared every cycle against a queue-based behavioural model.
module tb_prbs7_checker;
    localparam int LOCK_CNT    = 16;
    localparam int LOSS_THRESH = 8;
    localparam int WIN_LEN     = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prbs7_checker_if #(.ERR_CNT_W(16)) bus16 ();
    prbs7_checker_if #(.ERR_CNT_W(4))  bus4 ();

    prbs7_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .WIN_LEN(WIN_LEN),
                    .ERR_CNT_W(16))
        dut16 (.clk_i(clk), .rst_ni(rst_n), .bus(bus16));
    prbs7_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_THRESH(LOSS_THRESH), .WIN_LEN(WIN_LEN),
                    .ERR_CNT_W(4))
        dut4 (.clk_i(clk), .rst_ni(rst_n), .bus(bus4));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Generator: sliding window of the last seven bits, s[n] = s[n-6] ^ s[n-7].
    bit gq[$];
    task automatic gen_reset();
        gq = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    endtask
    function automatic bit gen_bit();
        bit b;
        b = gq[0];
        gq.push_back(gq[0] ^ gq[1]);
        void'(gq.pop_front());
        return b;
    endfunction

    // Reference model: received/predicted history as a queue, plain integer counters.
    bit hq[$];
    bit m_locked;
    bit m_err;
    int m_match, m_win, m_werr, m_cnt, m_bits;

    task automatic model_reset();
        hq.delete();
        m_locked = 0; m_err = 0;
        m_match = 0; m_win = 0; m_werr = 0; m_cnt = 0; m_bits = 0;
    endtask

    function automatic bit hist_nonzero();
        foreach (hq[i]) if (hq[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic hist_push(input bit x);
        hq.push_back(x);
        if (hq.size() > 7) void'(hq.pop_front());
    endtask

    task automatic model_step(input bit en, input bit b, input bit clr);
        bit p, e, nerr;
        nerr = 1'b0;
        if (en) begin
            p = (hq.size() == 7) ? (hq[0] ^ hq[1]) : 1'b0;
            if (!m_locked) begin
                if (hq.size() == 7 && hist_nonzero() && b == p) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin
                        m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
                    end
                end else begin
                    m_match = 0;
                end
                hist_push(b);
            end else begin
                e = (b != p);
                nerr = e;
                if (e) m_cnt++;
                m_bits++;
                hist_push(p);
                if (e) m_werr++;
                if (e && m_werr == LOSS_THRESH) begin
                    m_locked = 0; hq.delete(); m_match = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WIN_LEN - 1) begin
                    m_win = 0; m_werr = 0;
                end else begin
                    m_win++;
                end
            end
        end
        if (clr) begin
            m_cnt = 0; m_bits = 0;
        end
        m_err = nerr;
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic compare_all();
        check_val("locked16", bus16.locked_o, m_locked);
        check_val("err16", bus16.err_o, m_err);
        check_val("cnt16", bus16.err_cnt_o, sat(m_cnt, 16));
        check_val("locked4", bus4.locked_o, m_locked);
        check_val("cnt4", bus4.err_cnt_o, sat(m_cnt, 4));
`ifdef PRBS7_CHECKER_BITCNT_EN
        check_val("bits16", bus16.bit_cnt_o, sat(m_bits, 16));
        check_val("bits4", bus4.bit_cnt_o, sat(m_bits, 4));
`endif
    endtask

    bit force_zero = 1'b0;

    task automatic drive(input bit en, input bit b, input bit clr);
        bus16.en_i = en; bus16.prbs_i = b; bus16.clear_i = clr;
        bus4.en_i  = en; bus4.prbs_i  = b; bus4.clear_i  = clr;
    endtask

    task automatic cycle(input bit en, input bit flip, input bit clr);
        bit b;
        if (force_zero)  b = 1'b0;
        else if (en)     b = gen_bit() ^ flip;
        else             b = 1'($urandom % 2);
        drive(en, b, clr);
        @(posedge clk);
        model_step(en, b, clr);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        model_reset();
        #2;
        check_val("rst_locked", bus16.locked_o, 0);
        check_val("rst_err", bus16.err_o, 0);
        check_val("rst_cnt16", bus16.err_cnt_o, 0);
        check_val("rst_cnt4", bus4.err_cnt_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Feed clean bits until lock, bounded; checks the bit count to lock.
    task automatic lock_clean(input string tag);
        int n;
        n = 0;
        while (n < 100 && !bus16.locked_o) begin
            cycle(1'b1, 1'b0, 1'b0);
            n++;
        end
        check_val(tag, n, 7 + LOCK_CNT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        gen_reset();
        do_reset();

        // Clean stream locks after fill + LOCK_CNT matches, then stays error-free.
        lock_clean("t1_lock_bits");
        repeat (1000) cycle(1'b1, 1'b0, 1'b0);
        check_val("t1_cnt", bus16.err_cnt_o, 0);

        // Single flipped bit gives one registered pulse.
        cycle(1'b1, 1'b1, 1'b0);
        check_val("t2_err_pulse", bus16.err_o, 1);
        cycle(1'b1, 1'b0, 1'b0);
        check_val("t2_err_gone", bus16.err_o, 0);
        repeat (50) cycle(1'b1, 1'b0, 1'b0);
        check_val("t2_cnt", bus16.err_cnt_o, 1);
        check_val("t2_locked", bus16.locked_o, 1);

        // Reset while locked, then all-zero input never locks.
        do_reset();
        force_zero = 1'b1;
        repeat (200) cycle(1'b1, 1'b0, 1'b0);
        force_zero = 1'b0;
        check_val("t3_locked", bus16.locked_o, 0);
        check_val("t3_cnt", bus16.err_cnt_o, 0);

        // Burst of LOSS_THRESH errors drops lock; clean stream relocks.
        do_reset();
        gen_reset();
        lock_clean("t4_lock_bits");
        repeat (LOSS_THRESH - 1) cycle(1'b1, 1'b1, 1'b0);
        check_val("t4_still_locked", bus16.locked_o, 1);
        cycle(1'b1, 1'b1, 1'b0);
        check_val("t4_lost", bus16.locked_o, 0);
        check_val("t4_cnt", bus16.err_cnt_o, LOSS_THRESH);
        lock_clean("t4_relock_bits");

        // Disabled cycles with random input change nothing.
        repeat (10) cycle(1'b0, 1'b0, 1'b0);
        check_val("t5_locked", bus16.locked_o, 1);
        repeat (40) cycle(1'b1, 1'b0, 1'b0);
        check_val("t5_cnt", bus16.err_cnt_o, LOSS_THRESH);

        // Counter saturation on the narrow instance, then clear beats a same-cycle error.
        cycle(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b1, 1'b0);
            repeat (150) cycle(1'b1, 1'b0, 1'b0);
        end
        check_val("t6_cnt4_sat", bus4.err_cnt_o, 15);
        check_val("t6_cnt16", bus16.err_cnt_o, 20);
        cycle(1'b1, 1'b1, 1'b1);
        check_val("t6_clr_cnt4", bus4.err_cnt_o, 0);
        check_val("t6_clr_cnt16", bus16.err_cnt_o, 0);
        check_val("t6_clr_err", bus16.err_o, 1);

        // Randomised mix of enables, errors and clears.
        for (int k = 0; k < 3000; k++) begin
            cycle(($urandom % 10) != 0, ($urandom % 60) == 0, ($urandom % 300) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
